// File: rtl/stack_reverser.sv
// ---------------------------------------------------------------------------
// stack_reverser
//
// Stream-side controller for an external DEPTH-entry LIFO stack. Words that
// arrive on the input stream are pushed straight into the stack. When a burst
// ends (in_last accepted, or the stack reaches capacity) the controller pops
// the stack one word at a time. Each popped word is returned on the output
// stream, so the burst comes back in reverse order.
//
// Parameters
//   DEPTH           stack capacity in words; must match the attached stack
//   CW              occupancy counter width
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset; also resets the stack
//   in_data         input word
//   in_valid        input word present
//   in_last         final word of burst, qualified by in_valid
//   in_ready        controller accepts the input word
//   out_data        reversed word (registered)
//   out_valid       out_data valid
//   out_last        last word of the drained burst, qualified by out_valid
//   out_ready       consumer accepts the output word
//   stk_write_data  stack write data
//   stk_push        stack push strobe
//   stk_pop         stack pop strobe
//   stk_read_data   stack read data, updated on the edge that samples stk_pop
//   stk_full        stack full flag
//   stk_empty       stack empty flag
//   sync_err        sticky: the stack was empty when data was expected
// ---------------------------------------------------------------------------
module stack_reverser #(
  parameter int DEPTH = 100,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [31:0] stk_write_data,
  output logic        stk_push,
  output logic        stk_pop,
  input  logic [31:0] stk_read_data,
  input  logic        stk_full,
  input  logic        stk_empty,
  output logic        sync_err
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          in_hs;
  logic          out_hs;
  logic          pop_miss;

  // State register. The reset also discards any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and stack-port logic. All combinational outputs are gated by
  // rst, so they read 0 while reset is held, whatever the state.
  always_comb begin
    state_next     = state;
    in_ready       = 1'b0;
    stk_push       = 1'b0;
    stk_pop        = 1'b0;
    stk_write_data = '0;
    in_hs          = 1'b0;
    out_hs         = 1'b0;
    pop_miss       = 1'b0;
    if (rst) begin
      case (state)
        FILL: begin
          in_ready = !stk_full && (cnt < DEPTH_C);
          if (in_valid && in_ready) begin
            in_hs          = 1'b1;
            stk_push       = 1'b1;
            stk_write_data = in_data;
            // The word that fills the last slot forces a drain even without
            // in_last; later words then start a fresh burst.
            if (in_last || (cnt == LAST_C)) begin
              state_next = POP;
            end
          end
        end
        POP: begin
          // An empty stack here means the stack and cnt disagree. Abandon the
          // burst instead of popping an empty stack.
          if (stk_empty) begin
            pop_miss   = 1'b1;
            state_next = FILL;
          end else begin
            stk_pop    = 1'b1;
            state_next = CAPT;
          end
        end
        CAPT: begin
          state_next = OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_hs     = 1'b1;
            state_next = (cnt > ONE_C) ? POP : FILL;
          end
        end
        default: begin
          state_next = FILL;
        end
      endcase
    end
  end

  // Occupancy counter, output register and sticky error flag. stk_read_data
  // becomes valid one edge after the pop, so it is captured at the end of
  // CAPT. The output register then holds it until the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (in_hs) begin
        cnt <= cnt + 1'b1;
      end
      if (pop_miss) begin
        cnt      <= '0;
        sync_err <= 1'b1;
      end
      if (state == CAPT) begin
        out_data  <= stk_read_data;
        out_valid <= 1'b1;
        out_last  <= (cnt == ONE_C);
      end
      if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        cnt       <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stack_reverser.sv
// ---------------------------------------------------------------------------
// tb_stack_reverser
//
// Testbench for stack_reverser. It contains the following parts:
//   - a behavioural 100-entry LIFO stack attached to the stack port
//   - a burst-level reference model: accepted words are collected, and each
//     finished burst is reversed into a queue of expected outputs
//   - one compare process that checks the DUT against the model every cycle
//   - directed bursts with hand-computed expected values and timing
// ---------------------------------------------------------------------------
module tb_stack_reverser;

  localparam int DEPTH = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic [31:0] stk_write_data;
  logic        stk_push;
  logic        stk_pop;
  logic [31:0] stk_read_data;
  logic        stk_full;
  logic        stk_empty;
  logic        sync_err;
  logic        force_empty = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  stack_reverser #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_last(out_last),
    .out_ready(out_ready),
    .stk_write_data(stk_write_data),
    .stk_push(stk_push),
    .stk_pop(stk_pop),
    .stk_read_data(stk_read_data),
    .stk_full(stk_full),
    .stk_empty(stk_empty),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural LIFO stack. force_empty lets the bench fake an empty flag.
  logic [31:0] stk_mem [DEPTH];
  int          stk_sp;

  assign stk_full  = (stk_sp == DEPTH);
  assign stk_empty = (stk_sp == 0) || force_empty;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stk_sp        <= 0;
      stk_read_data <= '0;
    end else begin
      if (stk_push && stk_sp < DEPTH) begin
        stk_mem[stk_sp] <= stk_write_data;
        stk_sp          <= stk_sp + 1;
      end
      if (stk_pop && stk_sp > 0) begin
        stk_read_data <= stk_mem[stk_sp - 1];
        stk_sp        <= stk_sp - 1;
      end
    end
  end

  // Burst-level reference model.
  logic [31:0] burst[$];
  logic [31:0] pending[$];
  bit          draining = 1'b0;
  bit          first_pop = 1'b0;
  bit          exp_sync = 1'b0;

  function automatic bit model_ready();
    return rst && !draining && !stk_full && (burst.size() < DEPTH);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        burst.delete();
        pending.delete();
        draining  = 1'b0;
        first_pop = 1'b0;
        exp_sync  = 1'b0;
      end else begin
        automatic bit acc = in_valid && model_ready();
        if (first_pop) begin
          first_pop = 1'b0;
          if (force_empty) begin
            pending.delete();
            draining = 1'b0;
            exp_sync = 1'b1;
          end
        end else if (draining && out_valid && out_ready) begin
          void'(pending.pop_front());
          if (pending.size() == 0) draining = 1'b0;
        end
        if (acc) begin
          burst.push_back(in_data);
          if (in_last || burst.size() == DEPTH) begin
            pending.delete();
            for (int i = burst.size() - 1; i >= 0; i--) pending.push_back(burst[i]);
            burst.delete();
            draining  = 1'b1;
            first_pop = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        automatic bit er = model_ready();
        checkOutput("in_ready", in_ready, er);
        checkOutput("stk_push", stk_push, in_valid && er);
        if (stk_push) checkOutput("stk_write_data", stk_write_data, in_data);
        checkOutput("push_pop_exclusive", stk_push && stk_pop, 1'b0);
        checkOutput("sync_err", sync_err, exp_sync);
        if (out_valid) begin
          if (pending.size() == 0) begin
            checkOutput("out_valid_unexpected", out_valid, 1'b0);
          end else begin
            checkOutput("out_data", out_data, pending[0]);
            checkOutput("out_last", out_last, pending.size() == 1);
          end
        end
      end
    end
  end

  // Output handshake log and strobe counters.
  logic [31:0] log_data[$];
  bit          log_last[$];
  int          log_cyc[$];
  int          push_cnt = 0;
  int          pop_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (stk_push) push_cnt++;
        if (stk_pop) pop_cnt++;
        if (out_valid && out_ready) begin
          log_data.push_back(out_data);
          log_last.push_back(out_last);
          log_cyc.push_back(cyc);
        end
      end
    end
  end

  // Offer one word. The task returns 1 ns after the handshake edge, and
  // acc_cyc holds the cycle number of that edge.
  task automatic applyStimulus(input logic [31:0] d, input bit last, output int acc_cyc);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    acc_cyc  = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    if (acc_cyc < 0) failNow("accept");
  endtask

  // Wait for the controller to return to FILL. ready_cyc is the first cycle
  // in which in_ready is seen.
  task automatic waitIdle(output int ready_cyc);
    ready_cyc = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ready_cyc = cyc;
        break;
      end
    end
    if (ready_cyc < 0) failNow("idle");
    @(posedge clk);
    #1;
  endtask

  task automatic waitOutValid();
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) failNow("out_valid_wait");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a, a0, r, b, p0, rel;

    // Reset state while rst is held low, with a word offered.
    in_valid = 1'b1;
    #12;
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_stk_push", stk_push, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_out_last", out_last, 1'b0);
    checkOutput("rst_sync_err", sync_err, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Three-word burst.
    $display("[TB] three-word burst");
    b  = log_data.size();
    p0 = push_cnt;
    applyStimulus(32'h11, 1'b0, a);
    applyStimulus(32'h22, 1'b0, a);
    applyStimulus(32'h33, 1'b1, a0);
    waitIdle(r);
    checkOutput("t1_push_count", push_cnt - p0, 3);
    checkOutput("t1_out_count", log_data.size() - b, 3);
    checkOutput("t1_d0", log_data[b], 32'h33);
    checkOutput("t1_d1", log_data[b+1], 32'h22);
    checkOutput("t1_d2", log_data[b+2], 32'h11);
    checkOutput("t1_l0", log_last[b], 1'b0);
    checkOutput("t1_l1", log_last[b+1], 1'b0);
    checkOutput("t1_l2", log_last[b+2], 1'b1);
    checkOutput("t1_first_latency", log_cyc[b] - a0, 2);
    checkOutput("t1_spacing0", log_cyc[b+1] - log_cyc[b], 3);
    checkOutput("t1_spacing1", log_cyc[b+2] - log_cyc[b+1], 3);
    checkOutput("t1_ready_return", r - log_cyc[b+2], 1);

    // Single word.
    $display("[TB] single word");
    b  = log_data.size();
    p0 = pop_cnt;
    applyStimulus(32'hDEADBEEF, 1'b1, a0);
    waitIdle(r);
    checkOutput("t2_pop_count", pop_cnt - p0, 1);
    checkOutput("t2_out_count", log_data.size() - b, 1);
    checkOutput("t2_data", log_data[b], 32'hDEADBEEF);
    checkOutput("t2_last", log_last[b], 1'b1);
    checkOutput("t2_latency", log_cyc[b] - a0, 2);

    // 101 words without in_last: forced drain at capacity.
    $display("[TB] forced drain");
    b = log_data.size();
    for (int i = 1; i <= 100; i++) applyStimulus(32'h1000 + i, 1'b0, a);
    @(negedge clk);
    checkOutput("t3_ready_after_100", in_ready, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(32'h1000 + 101, 1'b1, a);
    waitIdle(r);
    checkOutput("t3_out_count", log_data.size() - b, 101);
    for (int k = 0; k < 100; k++) begin
      checkOutput("t3_data", log_data[b+k], 32'h1000 + 100 - k);
      checkOutput("t3_last", log_last[b+k], k == 99);
    end
    checkOutput("t3_new_burst_data", log_data[b+100], 32'h1065);
    checkOutput("t3_new_burst_last", log_last[b+100], 1'b1);

    // Output stall for 10 cycles.
    $display("[TB] output stall");
    b = log_data.size();
    out_ready = 1'b0;
    applyStimulus(32'hA1, 1'b0, a);
    applyStimulus(32'hA2, 1'b1, a);
    waitOutValid();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("t4_hold_valid", out_valid, 1'b1);
      checkOutput("t4_hold_data", out_data, 32'hA2);
      checkOutput("t4_hold_last", out_last, 1'b0);
      checkOutput("t4_hold_pop", stk_pop, 1'b0);
      checkOutput("t4_hold_push", stk_push, 1'b0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    rel = cyc;
    waitIdle(r);
    checkOutput("t4_out_count", log_data.size() - b, 2);
    checkOutput("t4_release_cycle", log_cyc[b], rel);
    checkOutput("t4_d0", log_data[b], 32'hA2);
    checkOutput("t4_d1", log_data[b+1], 32'hA1);
    checkOutput("t4_l1", log_last[b+1], 1'b1);

    // Asynchronous reset in the middle of a drain, with cnt at 5.
    $display("[TB] reset mid-drain");
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) applyStimulus(32'h50 + i, i == 5, a);
    waitOutValid();
    checkOutput("t5_pre_data", out_data, 32'h55);
    #2 rst = 1'b0;
    #1;
    checkOutput("t5_out_valid", out_valid, 1'b0);
    checkOutput("t5_out_data", out_data, 32'h0);
    checkOutput("t5_out_last", out_last, 1'b0);
    checkOutput("t5_in_ready", in_ready, 1'b0);
    checkOutput("t5_stk_push", stk_push, 1'b0);
    checkOutput("t5_stk_pop", stk_pop, 1'b0);
    checkOutput("t5_stk_wdata", stk_write_data, 32'h0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_ready_after_rst", in_ready, 1'b1);
    @(posedge clk);
    #1;
    b = log_data.size();
    applyStimulus(32'h77, 1'b0, a);
    applyStimulus(32'h88, 1'b1, a);
    waitIdle(r);
    checkOutput("t5_out_count", log_data.size() - b, 2);
    checkOutput("t5_d0", log_data[b], 32'h88);
    checkOutput("t5_d1", log_data[b+1], 32'h77);
    checkOutput("t5_l1", log_last[b+1], 1'b1);

    // Stack reports empty during POP.
    $display("[TB] sync error");
    b = log_data.size();
    applyStimulus(32'hB1, 1'b0, a);
    applyStimulus(32'hB2, 1'b1, a);
    force_empty = 1'b1;
    @(negedge clk);
    checkOutput("t6_no_pop", stk_pop, 1'b0);
    @(posedge clk);
    #1 force_empty = 1'b0;
    @(negedge clk);
    checkOutput("t6_sync_err_set", sync_err, 1'b1);
    checkOutput("t6_back_to_fill", in_ready, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(32'hC1, 1'b0, a);
    applyStimulus(32'hC2, 1'b1, a);
    waitIdle(r);
    checkOutput("t6_out_count", log_data.size() - b, 2);
    checkOutput("t6_d0", log_data[b], 32'hC2);
    checkOutput("t6_d1", log_data[b+1], 32'hC1);
    checkOutput("t6_sync_err_sticky", sync_err, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("t6_sync_err_reset", sync_err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_reverser.md
# stack_reverser

Stream-side controller that drives a 100-entry LIFO stack through its push/pop port. It accepts bursts of 32-bit words on a valid/ready input and pushes each word into the stack. On burst end it pops the stack and returns the words in reverse order on a valid/ready output. It is the initiator side of the stack interface and sits between a producer stream and the stack, which shares its clock and reset.

## Interface
- DEPTH, 100, stack capacity in words; must equal the attached stack's capacity.
- CW, $clog2(DEPTH+1) (7), occupancy counter width.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0). Must also reset the attached stack.
- in_data  in  32  input word.
- in_valid  in  1  input word present.
- in_last  in  1  final word of burst; qualified by in_valid.
- in_ready  out  1  block accepts input word.
- out_data  out  32  reversed word (registered).
- out_valid  out  1  out_data valid.
- out_last  out  1  last word of drained burst; qualified by out_valid.
- out_ready  in  1  consumer accepts output word.
- stk_write_data  out  32  to stack write_data.
- stk_push  out  1  to stack push.
- stk_pop  out  1  to stack pop.
- stk_read_data  in  32  from stack read_data; updated on the edge that samples stk_pop.
- stk_full  in  1  from stack.
- stk_empty  in  1  from stack.
- sync_err  out  1  sticky: stack reported empty when the block expected data.

## Operation
- States: FILL, POP, CAPT, OUT. The state register and the counter `cnt` are the only control state.
- FILL:
  - in_ready = !stk_full && cnt < DEPTH.
  - On handshake (in_valid && in_ready): stk_push=1 and stk_write_data=in_data, both combinational in the same cycle; cnt += 1.
  - Go to POP if in_last is accepted, or if the accepted word makes cnt==DEPTH (forced drain). After a forced drain, later input words form a new burst.
  - stk_push is 0 outside FILL handshakes.
- POP:
  - stk_pop=1 for exactly one cycle; next state CAPT.
  - If stk_empty=1 in POP: no pop is issued, sync_err is set, cnt is cleared, next state FILL.
- CAPT: at cycle end, out_data <= stk_read_data, out_valid <= 1, out_last <= (cnt==1). Next state OUT.
- OUT:
  - Hold out_data, out_valid and out_last stable until out_ready.
  - On handshake: out_valid <= 0, out_last <= 0, cnt -= 1. Next state POP if cnt>1, else FILL.
- stk_push and stk_pop are never both 1. in_ready is 0 in every state except FILL.
- cnt never exceeds DEPTH and never wraps. A decrement at 0 cannot occur.
- sync_err clears only on reset.
- Reset (rst=0, asynchronous, any state):
  - state=FILL, cnt=0, out_data=0, out_valid=0, out_last=0, sync_err=0.
  - stk_push=0, stk_pop=0, stk_write_data=0, in_ready=0 while rst=0.
  - An in-flight burst is discarded; the stack is reset by the same signal.

## Timing
- Push: zero-latency pass-through; the word is written at the handshake edge.
- Last input handshake at edge E0: stk_pop high in cycle E0–E1; out_valid rises after E2.
- Steady drain: one output word per 3 cycles when out_ready=1 (POP, CAPT, OUT).
- After the final output handshake, in_ready is 1 in the next cycle (FILL), unless the stack is full.
- A burst of N words occupies N input cycles + 3N output cycles minimum.

## Test plan
- Burst 0x11,0x22,0x33 (in_last on 0x33), out_ready=1: stk_push high 3 cycles; out sequence 0x33,0x22,0x11 at 3-cycle spacing, out_last only with 0x11; in_ready returns 1 afterwards.
- Single word 0xDEADBEEF with in_last: exactly one stk_pop; out_data=0xDEADBEEF with out_last=1 appears 2 edges after acceptance; cnt back to 0.
- 101 words without in_last: in_ready drops after the 100th; words 100..1 emerge reversed, out_last with word 1; word 101 is then accepted as a new burst.
- out_ready held 0 for 10 cycles in OUT: out_data, out_valid and out_last are stable; stk_pop and stk_push stay 0; word released on the first out_ready=1.
- rst pulled low mid-drain (cnt=5): all outputs 0 immediately, without waiting for a clock edge; after release, state is FILL, in_ready=1, and a new 2-word burst reverses correctly.
- stk_empty forced 1 while in POP: no stk_pop, sync_err=1 and it remains 1 through later bursts until reset.
